// File: rtl/xrv1_rf_sb.sv
// Multi-port integer register file with a per-register pending-write scoreboard.
// Define XRV1_RF_BYPASS_EN to forward same-cycle write data (and busy clears) to the read ports.
module xrv1_rf_sb #(
  parameter int data_width_p    = 32,
  parameter int rf_addr_width_p = 5,
  parameter int num_rd_p        = 2,
  parameter int num_wr_p        = 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [num_rd_p*rf_addr_width_p-1:0]  rs_addr_i,
  output logic [num_rd_p*data_width_p-1:0]     rs_data_o,
  output logic [num_rd_p-1:0]                  rs_busy_o,
  input  logic [num_wr_p-1:0]                  rd_w_en_i,
  input  logic [num_wr_p*rf_addr_width_p-1:0]  rd_addr_i,
  input  logic [num_wr_p*data_width_p-1:0]     rd_data_i,
  input  logic                                 alloc_en_i,
  input  logic [rf_addr_width_p-1:0]           alloc_addr_i,
  input  logic                                 flush_i,
  output logic                                 sb_empty_o
);

  localparam int rf_size_lp = 1 << rf_addr_width_p;

  logic [data_width_p-1:0]    mem_q [rf_size_lp];
  logic [rf_size_lp-1:0]      busy_q;
  logic [rf_size_lp-1:0]      busy_d;
  logic [rf_addr_width_p-1:0] wrAddr [num_wr_p];
  logic [data_width_p-1:0]    wrData [num_wr_p];
  logic [rf_addr_width_p-1:0] rsAddr [num_rd_p];

  always_comb begin
    for (int j = 0; j < num_wr_p; j++) begin
      wrAddr[j] = rd_addr_i[j*rf_addr_width_p +: rf_addr_width_p];
      wrData[j] = rd_data_i[j*data_width_p +: data_width_p];
    end
    for (int k = 0; k < num_rd_p; k++) begin
      rsAddr[k] = rs_addr_i[k*rf_addr_width_p +: rf_addr_width_p];
    end
  end

  // Later assignments override earlier ones: write clear, then alloc, then flush.
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < num_wr_p; j++) begin
      if (rd_w_en_i[j]) begin
        busy_d[wrAddr[j]] = 1'b0;
      end
    end
    if (alloc_en_i) begin
      busy_d[alloc_addr_i] = 1'b1;
    end
    if (flush_i) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  // Port loop order makes the highest-indexed write port win on collisions.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int r = 0; r < rf_size_lp; r++) begin
        mem_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int j = 0; j < num_wr_p; j++) begin
        if (rd_w_en_i[j] && (wrAddr[j] != '0)) begin
          mem_q[wrAddr[j]] <= wrData[j];
        end
      end
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rs_data_o = '0;
    rs_busy_o = '0;
    for (int k = 0; k < num_rd_p; k++) begin
      if (rsAddr[k] != '0) begin
        rs_data_o[k*data_width_p +: data_width_p] = mem_q[rsAddr[k]];
        rs_busy_o[k] = busy_q[rsAddr[k]];
`ifdef XRV1_RF_BYPASS_EN
        for (int j = 0; j < num_wr_p; j++) begin
          if (rd_w_en_i[j] && (wrAddr[j] == rsAddr[k])) begin
            rs_data_o[k*data_width_p +: data_width_p] = wrData[j];
            if (!(alloc_en_i && (alloc_addr_i == rsAddr[k]))) begin
              rs_busy_o[k] = 1'b0;
            end
          end
        end
`endif
      end
    end
  end

  assign sb_empty_o = ~|busy_q;

endmodule

// File: tb/tb_xrv1_rf_sb.sv
// Directed self-checking bench for xrv1_rf_sb with two read and two write ports.
// Same-cycle read expectations follow whether XRV1_RF_BYPASS_EN is defined.
module tb_xrv1_rf_sb;

  logic        clk_i;
  logic        rst_i;
  logic [9:0]  rs_addr_i;
  logic [63:0] rs_data_o;
  logic [1:0]  rs_busy_o;
  logic [1:0]  rd_w_en_i;
  logic [9:0]  rd_addr_i;
  logic [63:0] rd_data_i;
  logic        alloc_en_i;
  logic [4:0]  alloc_addr_i;
  logic        flush_i;
  logic        sb_empty_o;

  int checkCount = 0;
  int errorCount = 0;

  xrv1_rf_sb #(
    .data_width_p(32),
    .rf_addr_width_p(5),
    .num_rd_p(2),
    .num_wr_p(2)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .rs_addr_i(rs_addr_i),
    .rs_data_o(rs_data_o),
    .rs_busy_o(rs_busy_o),
    .rd_w_en_i(rd_w_en_i),
    .rd_addr_i(rd_addr_i),
    .rd_data_i(rd_data_i),
    .alloc_en_i(alloc_en_i),
    .alloc_addr_i(alloc_addr_i),
    .flush_i(flush_i),
    .sb_empty_o(sb_empty_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] wen, input logic [4:0] wa0, input logic [31:0] wd0,
                               input logic [4:0] wa1, input logic [31:0] wd1,
                               input logic alloc, input logic [4:0] allocAddr, input logic flush);
    rd_w_en_i    = wen;
    rd_addr_i    = {wa1, wa0};
    rd_data_i    = {wd1, wd0};
    alloc_en_i   = alloc;
    alloc_addr_i = allocAddr;
    flush_i      = flush;
  endtask

  task automatic idle;
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic readRegs(input logic [4:0] a0, input logic [4:0] a1);
    rs_addr_i = {a1, a0};
    #1;
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b0;
    idle();
    readRegs(5'd5, 5'd6);
    tick();
    tick();
    checkOutput("rst_empty", {31'h0, sb_empty_o}, 32'h1);
    checkOutput("rst_data0", rs_data_o[31:0], 32'h0);
    checkOutput("rst_busy1", {30'h0, rs_busy_o}, 32'h0);
    rst_i = 1'b1;

    // Async reset between edges
    applyStimulus(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b1, 5'd6, 1'b0);
    tick();
    idle();
    readRegs(5'd5, 5'd6);
    checkOutput("pre_rst_data", rs_data_o[31:0], 32'hDEADBEEF);
    checkOutput("pre_rst_busy", {30'h0, rs_busy_o}, 32'h2);
    checkOutput("pre_rst_empty", {31'h0, sb_empty_o}, 32'h0);
    #2;
    rst_i = 1'b0;
    #1;
    checkOutput("async_rst_data", rs_data_o[31:0], 32'h0);
    checkOutput("async_rst_empty", {31'h0, sb_empty_o}, 32'h1);
    checkOutput("async_rst_busy", {30'h0, rs_busy_o}, 32'h0);
    tick();
    rst_i = 1'b1;

    // Write lost when reset arrives in the write cycle
    applyStimulus(2'b01, 5'd8, 32'h00000077, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(2'b01, 5'd8, 32'h00000088, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    idle();
    readRegs(5'd8, 5'd8);
    checkOutput("rst_midwrite", rs_data_o[31:0], 32'h0);

    // x0 is hardwired
    applyStimulus(2'b01, 5'd0, 32'h12345678, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0);
    tick();
    idle();
    readRegs(5'd0, 5'd0);
    checkOutput("x0_data", rs_data_o[63:32], 32'h0);
    checkOutput("x0_busy", {30'h0, rs_busy_o}, 32'h0);
    checkOutput("x0_empty", {31'h0, sb_empty_o}, 32'h1);

    // Write collision and independent writes
    applyStimulus(2'b11, 5'd3, 32'h11, 5'd3, 32'h22, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(2'b11, 5'd12, 32'hAA, 5'd13, 32'hBB, 1'b0, 5'd0, 1'b0);
    tick();
    idle();
    readRegs(5'd3, 5'd3);
    checkOutput("collide_p0", rs_data_o[31:0], 32'h22);
    checkOutput("collide_p1", rs_data_o[63:32], 32'h22);
    readRegs(5'd12, 5'd13);
    checkOutput("dual_wr_p0", rs_data_o[31:0], 32'hAA);
    checkOutput("dual_wr_p1", rs_data_o[63:32], 32'hBB);

    // Scoreboard allocate then clear
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0);
    tick();
    idle();
    readRegs(5'd7, 5'd3);
    checkOutput("alloc_busy", {30'h0, rs_busy_o}, 32'h1);
    checkOutput("alloc_empty", {31'h0, sb_empty_o}, 32'h0);
    tick();
    tick();
    applyStimulus(2'b01, 5'd7, 32'hA5, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    readRegs(5'd7, 5'd7);
`ifdef XRV1_RF_BYPASS_EN
    checkOutput("wr_cycle_data", rs_data_o[31:0], 32'hA5);
    checkOutput("wr_cycle_busy", {30'h0, rs_busy_o}, 32'h0);
`else
    checkOutput("wr_cycle_data", rs_data_o[31:0], 32'h0);
    checkOutput("wr_cycle_busy", {30'h0, rs_busy_o}, 32'h3);
`endif
    tick();
    idle();
    readRegs(5'd7, 5'd7);
    checkOutput("wr_clr_data", rs_data_o[31:0], 32'hA5);
    checkOutput("wr_clr_busy", {30'h0, rs_busy_o}, 32'h0);
    checkOutput("wr_clr_empty", {31'h0, sb_empty_o}, 32'h1);
    applyStimulus(2'b01, 5'd7, 32'h5A, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0);
    tick();
    idle();
    readRegs(5'd7, 5'd7);
    checkOutput("alloc_wins_busy", {30'h0, rs_busy_o}, 32'h3);
    checkOutput("alloc_wins_data", rs_data_o[63:32], 32'h5A);
    applyStimulus(2'b10, 5'd0, 32'h0, 5'd7, 32'h66, 1'b0, 5'd0, 1'b0);
    tick();
    idle();
    readRegs(5'd7, 5'd7);
    checkOutput("p1_clear_busy", {30'h0, rs_busy_o}, 32'h0);

    // Top register
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd31, 1'b0);
    tick();
    idle();
    readRegs(5'd0, 5'd31);
    checkOutput("x31_busy", {30'h0, rs_busy_o}, 32'h2);
    applyStimulus(2'b10, 5'd0, 32'h0, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0, 1'b0);
    tick();
    idle();
    readRegs(5'd0, 5'd31);
    checkOutput("x31_data", rs_data_o[63:32], 32'hFFFFFFFF);
    checkOutput("x31_clr", {30'h0, rs_busy_o}, 32'h0);

    // Flush beats same-cycle alloc, same-cycle write still lands
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b0);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0);
    tick();
    idle();
    readRegs(5'd1, 5'd2);
    checkOutput("pre_flush_empty", {31'h0, sb_empty_o}, 32'h0);
    checkOutput("pre_flush_busy", {30'h0, rs_busy_o}, 32'h3);
    applyStimulus(2'b01, 5'd2, 32'h99, 5'd0, 32'h0, 1'b1, 5'd4, 1'b1);
    tick();
    idle();
    readRegs(5'd1, 5'd4);
    checkOutput("flush_empty", {31'h0, sb_empty_o}, 32'h1);
    checkOutput("flush_busy", {30'h0, rs_busy_o}, 32'h0);
    readRegs(5'd2, 5'd9);
    checkOutput("flush_wr_data", rs_data_o[31:0], 32'h99);
    checkOutput("flush_busy9", {30'h0, rs_busy_o}, 32'h0);

    // Same-cycle write/read forwarding
    applyStimulus(2'b01, 5'd10, 32'h1111, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(2'b01, 5'd10, 32'hCAFE, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    readRegs(5'd10, 5'd0);
`ifdef XRV1_RF_BYPASS_EN
    checkOutput("byp_same_cycle", rs_data_o[31:0], 32'hCAFE);
`else
    checkOutput("byp_same_cycle", rs_data_o[31:0], 32'h1111);
`endif
    tick();
    idle();
    readRegs(5'd10, 5'd0);
    checkOutput("byp_next_cycle", rs_data_o[31:0], 32'hCAFE);
    applyStimulus(2'b10, 5'd0, 32'h0, 5'd0, 32'hBEEF, 1'b0, 5'd0, 1'b0);
    readRegs(5'd0, 5'd0);
    checkOutput("byp_x0", rs_data_o[63:32], 32'h0);
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd10, 1'b0);
    tick();
    applyStimulus(2'b01, 5'd10, 32'hD00D, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    readRegs(5'd10, 5'd10);
`ifdef XRV1_RF_BYPASS_EN
    checkOutput("byp_busy_fwd", {30'h0, rs_busy_o}, 32'h0);
`else
    checkOutput("byp_busy_fwd", {30'h0, rs_busy_o}, 32'h3);
`endif
    applyStimulus(2'b01, 5'd10, 32'hD00D, 5'd0, 32'h0, 1'b1, 5'd10, 1'b0);
    readRegs(5'd10, 5'd10);
    checkOutput("byp_busy_alloc", {30'h0, rs_busy_o}, 32'h3);
    tick();
    idle();
    readRegs(5'd10, 5'd10);
    checkOutput("byp_alloc_after", {30'h0, rs_busy_o}, 32'h3);
    checkOutput("byp_alloc_data", rs_data_o[31:0], 32'hD00D);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
